// File: rtl/sipo_frame_rx_if.sv
// Receiver-side bus for sipo_frame_rx: serial input controls plus the
// one-entry output buffer handshake and status flags.
interface sipo_frame_rx_if #(
    parameter int NUM_BITS = 8
);
    logic                serial_in;
    logic                bit_en;
    logic                start;
    logic                dir;
    logic                out_ready;
    logic                clr_err;
    logic [NUM_BITS-1:0] data_out;
    logic                data_valid;
    logic                busy;
    logic                overrun;
    logic                frame_err;

    // Producer/consumer side: drives the serial line and the ready/clear controls.
    modport master (
        output serial_in, bit_en, start, dir, out_ready, clr_err,
        input  data_out, data_valid, busy, overrun, frame_err
    );

    // Receiver side.
    modport slave (
        input  serial_in, bit_en, start, dir, out_ready, clr_err,
        output data_out, data_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver. Collects NUM_BITS strobed bits
// (LSB- or MSB-first, order latched at start) into a word, hands it out
// through a one-entry valid/ready buffer, and flags overrun and
// inter-bit timeout as sticky errors.
module sipo_frame_rx #(
    parameter int NUM_BITS = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    sipo_frame_rx_if.slave  bus
);
    localparam int CW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
    // Timeout fires on the edge where idle_cnt would reach TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] sh_q, sh_next, data_q;
    logic [CW-1:0]       bit_cnt_q;
    logic [TW-1:0]       idle_cnt_q;
    logic                dir_q, valid_q, ovr_q, ferr_q;
    logic                start_ok, done, tmo, buf_free;

    // Shift register value after sampling serial_in, in the latched bit order.
    always_comb begin
        sh_next = sh_q;
        if (dir_q) sh_next = {sh_q[NUM_BITS-2:0], bus.serial_in};
        else       sh_next = {bus.serial_in, sh_q[NUM_BITS-1:1]};
    end

    // Next-state decode: frame start, completion on the last strobe, timeout abort.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_ok = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end else if (TIMEOUT != 0 && idle_cnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Shift datapath, bit counter, inter-bit idle counter and latched direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            dir_q      <= 1'b0;
        end else if (start_ok) begin
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            dir_q      <= bus.dir;
        end else if (state_q == SHIFT) begin
            if (bus.bit_en) begin
                sh_q       <= sh_next;
                bit_cnt_q  <= done ? '0 : bit_cnt_q + 1'b1;
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    // A completing word may reuse the slot in the same cycle it is drained.
    assign buf_free = !valid_q || bus.out_ready;

    // Output buffer and sticky errors; a new event wins over a same-edge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (done && buf_free) begin
                data_q  <= sh_next;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            ovr_q  <= (ovr_q  & ~bus.clr_err) | (done & ~buf_free);
            ferr_q <= (ferr_q & ~bus.clr_err) | tmo;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
endmodule
